yarvi_loader: RTL and testbench

Byte-stream loader that fills the instruction memory read by the fetch stage and then redirects fetch to the loaded image. It sits between a host byte source (UART or debug bridge) and the core: it drives the code-memory write port and the fetch `restart`/`restart_pc` pair. The frame format is a load address, a word count and the data words, all little-endian.

---
 rtl/yarvi_loader.sv | 250 +++++++++++++++++++++++++
 tb/tb_yarvi_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/yarvi_loader.sv
// yarvi_loader: byte-stream loader that fills code memory, then redirects fetch to the image.
// Latency: code_we one cycle after a data word's 4th byte; restart one cycle after the DONE state.
// Backpressure: in_ready drops only during the single DONE cycle; in_valid gaps hold partial fields.
// Build option: define YARVI_LOADER_CSUM_EN to require a wrapping-sum trailer after the data words.
module yarvi_loader #(
    parameter int CODE_AW = 10,
    parameter int VMSB    = 31
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               code_we,
    output logic [CODE_AW-1:0] code_addr,
    output logic [31:0]        code_wdata,
    output logic               restart,
    output logic [VMSB:0]      restart_pc,
    output logic               busy,
    output logic               error
);

    // Frame sequencing states
    localparam logic [2:0] S_ADDR  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
`ifdef YARVI_LOADER_CSUM_EN
    localparam logic [2:0] S_CSUM  = 3'd3;
`endif
    localparam logic [2:0] S_DONE  = 3'd4;

    // Where the frame goes once the data words (or an empty count) are finished
`ifdef YARVI_LOADER_CSUM_EN
    localparam logic [2:0] S_AFTER_DATA = S_CSUM;
`else
    localparam logic [2:0] S_AFTER_DATA = S_DONE;
`endif

    // Sequencer state
    logic [2:0]         r_state;
    logic [1:0]         r_cnt;
    logic [23:0]        r_shift;

    // Frame context
    logic [31:0]        r_addr;
    logic [31:0]        r_remain;
    logic [CODE_AW-1:0] r_widx;

    // Registered outputs
    logic               r_in_ready;
    logic               r_we;
    logic [CODE_AW-1:0] r_code_addr;
    logic [31:0]        r_code_wdata;
    logic               r_restart;
    logic [VMSB:0]      r_restart_pc;
    logic               r_busy;
    logic               r_error;

`ifdef YARVI_LOADER_CSUM_EN
    logic [31:0]        r_sum;
    logic               r_csum_bad;
`endif

    // Combinational helpers
    logic               w_fire;
    logic               w_last_byte;
    logic               w_field_done;
    logic [31:0]        w_field;
    logic               w_misaligned;
    logic               w_bad;
    logic [2:0]         w_state_nxt;
    logic [1:0]         w_cnt_nxt;

    assign w_fire       = in_valid & r_in_ready;
    assign w_last_byte  = (r_cnt == 2'd3);
    assign w_field_done = w_fire & w_last_byte;
    // Fields arrive LSB-first, so the completing byte is the top byte
    assign w_field      = {in_data, r_shift};
    assign w_misaligned = (r_addr[1:0] != 2'b00);

`ifdef YARVI_LOADER_CSUM_EN
    assign w_bad = w_misaligned | r_csum_bad;
`else
    assign w_bad = w_misaligned;
`endif

    // Next-state and byte-counter logic for the frame sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_fire) begin
            w_cnt_nxt = r_cnt + 2'd1;
        end
        case (r_state)
            S_ADDR: begin
                if (w_field_done) begin
                    w_state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                if (w_field_done) begin
                    w_state_nxt = (w_field == 32'd0) ? S_AFTER_DATA : S_DATA;
                end
            end
            S_DATA: begin
                if (w_field_done && (r_remain == 32'd1)) begin
                    w_state_nxt = S_AFTER_DATA;
                end
            end
`ifdef YARVI_LOADER_CSUM_EN
            S_CSUM: begin
                if (w_field_done) begin
                    w_state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_state_nxt = S_ADDR;
            end
            default: begin
                w_state_nxt = S_ADDR;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    // State, byte counter and the handshake/status flags derived from the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_ADDR;
            r_cnt      <= 2'd0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_in_ready <= (w_state_nxt != S_DONE);
            r_busy     <= (w_state_nxt != S_ADDR) || (w_cnt_nxt != 2'd0);
        end
    end

    // Hold the first three bytes of a field until the fourth completes it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift <= 24'd0;
        end else if (w_fire && !w_last_byte) begin
            r_shift <= {in_data, r_shift[23:8]};
        end
    end

    // Capture load address and word count; step the word index and remaining count per data word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr   <= 32'd0;
            r_remain <= 32'd0;
            r_widx   <= '0;
        end else if (w_field_done) begin
            case (r_state)
                S_ADDR: begin
                    r_addr <= w_field;
                    r_widx <= w_field[CODE_AW+1:2];
                end
                S_COUNT: begin
                    r_remain <= w_field;
                end
                S_DATA: begin
                    r_remain <= r_remain - 32'd1;
                    r_widx   <= r_widx + CODE_AW'(1);
                end
                default: begin
                    r_remain <= r_remain;
                end
            endcase
        end
    end

    // Code-memory write port: one strobe per completed data word, muted for a misaligned frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_we         <= 1'b0;
            r_code_addr  <= '0;
            r_code_wdata <= 32'd0;
        end else begin
            r_we <= 1'b0;
            if (w_field_done && (r_state == S_DATA) && !w_misaligned) begin
                r_we         <= 1'b1;
                r_code_addr  <= r_widx;
                r_code_wdata <= w_field;
            end
        end
    end

`ifdef YARVI_LOADER_CSUM_EN
    // Running wrapping sum of the data words, compared against the trailer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sum      <= 32'd0;
            r_csum_bad <= 1'b0;
        end else if (w_field_done) begin
            case (r_state)
                S_COUNT: begin
                    r_sum      <= 32'd0;
                    r_csum_bad <= 1'b0;
                end
                S_DATA: begin
                    r_sum <= r_sum + w_field;
                end
                S_CSUM: begin
                    r_csum_bad <= (w_field != r_sum);
                end
                default: begin
                    r_sum <= r_sum;
                end
            endcase
        end
    end
`endif

    // Frame verdict: restart pulse for a good frame, sticky error for a bad one
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_restart    <= 1'b0;
            r_restart_pc <= '0;
            r_error      <= 1'b0;
        end else begin
            r_restart <= 1'b0;
            if ((r_state == S_ADDR) && w_fire && (r_cnt == 2'd0)) begin
                r_error <= 1'b0;
            end
            if (r_state == S_DONE) begin
                if (w_bad) begin
                    r_error <= 1'b1;
                end else begin
                    r_restart    <= 1'b1;
                    r_restart_pc <= (VMSB+1)'(r_addr);
                end
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign code_we    = r_we;
    assign code_addr  = r_code_addr;
    assign code_wdata = r_code_wdata;
    assign restart    = r_restart;
    assign restart_pc = r_restart_pc;
    assign busy       = r_busy;
    assign error      = r_error;

endmodule

// File: tb/tb_yarvi_loader.sv
// tb_yarvi_loader: frame-level bench for yarvi_loader.
// Expected writes/restarts are queued when a frame is driven and popped as the DUT produces them.
// Works in both builds; the checksum trailer is appended when YARVI_LOADER_CSUM_EN is defined.
module tb_yarvi_loader;

    localparam int AW = 10;
`ifdef YARVI_LOADER_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready;
    logic          code_we;
    logic [AW-1:0] code_addr;
    logic [31:0]   code_wdata;
    logic          restart;
    logic [31:0]   restart_pc;
    logic          busy;
    logic          error;

    yarvi_loader #(.CODE_AW(AW), .VMSB(31)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .code_we    (code_we),
        .code_addr  (code_addr),
        .code_wdata (code_wdata),
        .restart    (restart),
        .restart_pc (restart_pc),
        .busy       (busy),
        .error      (error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_we_cyc = -100;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        after_we;
    } rs_t;

    wr_t exp_wr[$];
    rs_t exp_rs[$];

    logic [31:0] fw [0:3];

    typedef struct {
        logic [31:0] addr;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    // Output monitor / scoreboard
    always @(negedge clock) begin
        wr_t w;
        rs_t r;
        if (code_we && restart) chk("we_restart_overlap", 1, 0);
        if (code_we) begin
            last_we_cyc = cyc;
            if (exp_wr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none", code_addr, code_wdata);
            end else begin
                w = exp_wr.pop_front();
                chk("write_addr", code_addr, w.addr);
                chk("write_data", code_wdata, w.data);
            end
        end
        if (restart) begin
            if (exp_rs.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_restart actual=%0h required=none", restart_pc);
            end else begin
                r = exp_rs.pop_front();
                chk("restart_pc", restart_pc, r.pc);
                if (r.after_we) chk("restart_latency", cyc - last_we_cyc, 1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_busy);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 20) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            if (chk_busy) chk("busy_in_gap", busy, 1);
            @(negedge clock);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input bit last);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], gap, !(last && k == 3));
        end
    endtask

    // Queue the model's expectations for a frame, then drive it byte by byte
    task automatic send_frame(input logic [31:0] a, input int n, input int gap,
                              input bit bad_sum, input bit chk_clear);
        logic [31:0] sum;
        logic [31:0] nn;
        logic        good;
        wr_t         w;
        rs_t         r;
        sum  = 32'd0;
        nn   = n;
        good = (a[1:0] == 2'b00);
        for (int i = 0; i < n; i++) begin
            sum = sum + fw[i];
            if (good) begin
                w.addr = AW'((a >> 2) + i);
                w.data = fw[i];
                exp_wr.push_back(w);
            end
        end
        if (good && !bad_sum) begin
            r.pc       = a;
            r.after_we = (n > 0) && !CSUM;
            exp_rs.push_back(r);
        end
        for (int k = 0; k < 4; k++) begin
            send_byte(a[8*k +: 8], gap, 1'b1);
            if (k == 0 && chk_clear) chk("error_clear", error, 0);
        end
        send_word(nn, gap, (n == 0) && !CSUM);
        for (int i = 0; i < n; i++) begin
            send_word(fw[i], gap, (i == n - 1) && !CSUM);
        end
        if (CSUM) send_word(bad_sum ? sum + 32'd1 : sum, gap, 1'b1);
    endtask

    task automatic post_frame(input string tag, input logic exp_err);
        repeat (4) @(negedge clock);
        chk({tag, "_error"}, error, exp_err);
        chk({tag, "_writes_left"}, exp_wr.size(), 0);
        chk({tag, "_restarts_left"}, exp_rs.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_code_we"}, code_we, 0);
        chk({tag, "_code_addr"}, code_addr, 0);
        chk({tag, "_code_wdata"}, code_wdata, 0);
        chk({tag, "_restart"}, restart, 0);
        chk({tag, "_restart_pc"}, restart_pc, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_t w;
        vecs[0] = '{addr: 32'h0000_0100, n: 2, w0: 32'h0000_0013, w1: 32'h0000_006F, exp_err: 1'b0};
        vecs[1] = '{addr: 32'h0000_0102, n: 1, w0: 32'hDEAD_BEEF, w1: 32'h0,         exp_err: 1'b1};
        vecs[2] = '{addr: 32'h0000_0FFC, n: 2, w0: 32'h1111_1111, w1: 32'h2222_2222, exp_err: 1'b0};
        vecs[3] = '{addr: 32'h0000_0200, n: 0, w0: 32'h0,         w1: 32'h0,         exp_err: 1'b0};
        vecs[4] = '{addr: 32'h1234_5678, n: 1, w0: 32'hCAFE_F00D, w1: 32'h0,         exp_err: 1'b0};

        #2 reset = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 5; i++) begin
            fw[0] = vecs[i].w0;
            fw[1] = vecs[i].w1;
            send_frame(vecs[i].addr, vecs[i].n, 0, 1'b0, (i > 0) && vecs[(i > 0) ? i - 1 : 0].exp_err);
            post_frame($sformatf("vec%0d", i), vecs[i].exp_err);
        end

        // Gapped stream: three idle cycles between every byte
        fw[0] = 32'h0000_0013;
        fw[1] = 32'h0000_006F;
        send_frame(32'h0000_0100, 2, 3, 1'b0, 1'b0);
        post_frame("gapped", 1'b0);

        // Misaligned frame, then error must clear on the next frame's first byte
        fw[0] = 32'h5555_AAAA;
        send_frame(32'h0000_0301, 1, 0, 1'b0, 1'b0);
        post_frame("misaligned2", 1'b1);
        fw[0] = 32'h0000_0013;
        fw[1] = 32'h0000_006F;
        send_frame(32'h0000_0100, 2, 0, 1'b0, 1'b1);
        post_frame("after_misaligned", 1'b0);

        // Reset mid-frame, right after the first data word's write
        w.addr = AW'(10'h100);
        w.data = 32'hAAAA_5555;
        exp_wr.push_back(w);
        send_word(32'h0000_0400, 0, 1'b0);
        send_word(32'd2, 0, 1'b0);
        send_word(32'hAAAA_5555, 0, 1'b0);
        @(negedge clock);
        chk("midreset_first_write_seen", exp_wr.size(), 0);
        #2 reset = 1'b1;
        #1 check_reset_outputs("midreset");
        @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        chk("midreset_quiet_busy", busy, 0);
        post_frame("midreset", 1'b0);
        fw[0] = 32'h0000_0013;
        fw[1] = 32'h0000_006F;
        send_frame(32'h0000_0100, 2, 0, 1'b0, 1'b0);
        post_frame("after_reset", 1'b0);

`ifdef YARVI_LOADER_CSUM_EN
        // Checksum mismatch: writes stand, no restart, error raised
        send_frame(32'h0000_0100, 2, 0, 1'b1, 1'b0);
        post_frame("csum_bad", 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
